// File: rtl/bundle_pkg.sv
// Shared definitions for the two-slot bundle sequencer.
//   - slot opcode constants (slot0: ALU reg/imm, slot1: load/store, both: NOP)
//   - controller state enum
//   - per-slot decode result struct
package bundle_pkg;

  localparam logic [4:0] OP_NOP     = 5'b00000;
  localparam logic [4:0] OP_ALU_REG = 5'b01000;
  localparam logic [4:0] OP_ALU_IMM = 5'b00101;
  localparam logic [4:0] OP_LOAD    = 5'b01010;
  localparam logic [4:0] OP_STORE   = 5'b01011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef struct packed {
    logic alu;      // slot0 ALU op (reg or imm)
    logic imm;      // slot0 ALU op uses offset/immediate as operand A
    logic load;     // slot1 load
    logic store;    // slot1 store
    logic illegal;  // opcode not legal for this slot
  } slot_dec_t;

  function automatic logic is_mem(input slot_dec_t d);
    return d.load | d.store;
  endfunction

endpackage

// File: rtl/slot_decode.sv
// Combinational opcode decoder for one bundle slot.
//   SLOT  : 0 decodes the ALU slot, 1 decodes the memory slot
//   op_i  : 5-bit slot opcode
//   dec_o : decoded flags; any opcode not legal for the slot sets illegal
module slot_decode
  import bundle_pkg::*;
#(
  parameter int SLOT = 0
) (
  input  logic [4:0] op_i,
  output slot_dec_t  dec_o
);

  generate
    if (SLOT == 0) begin : g_slot0
      always_comb begin
        dec_o = '0;
        case (op_i)
          OP_ALU_REG: dec_o.alu = 1'b1;
          OP_ALU_IMM: begin
            dec_o.alu = 1'b1;
            dec_o.imm = 1'b1;
          end
          OP_NOP:     ;
          default:    dec_o.illegal = 1'b1;
        endcase
      end
    end else begin : g_slot1
      always_comb begin
        dec_o = '0;
        case (op_i)
          OP_LOAD:  dec_o.load  = 1'b1;
          OP_STORE: dec_o.store = 1'b1;
          OP_NOP:   ;
          default:  dec_o.illegal = 1'b1;
        endcase
      end
    end
  endgenerate

endmodule

// File: rtl/bundle_seq.sv
// Two-slot bundle controller: IDLE -> DECODE -> [EXEC] -> [MEM] -> WB.
//   clk, reset        : clock, async active-high reset
//   instr_valid/instr : bundle offer; accepted while instr_ready (Moore, IDLE)
//   alu_en, aluSrcA   : slot0 execute pulse and held operand-A select
//   mem_req/mem_we    : slot1 memory request, held until mem_ack or timeout
//   mem_ack           : memory completion, only observed in MEM
//   regWrite1/2       : WB pulses for slot0 and completed slot1 loads
//   illegal           : bundle rejected in DECODE
//   mem_timeout       : MEM aborted after MEM_TIMEOUT cycles without ack
//   retired           : wrapping count of bundles that reached WB
module bundle_seq
  import bundle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic        alu_en,
  output logic        aluSrcA,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        regWrite1,
  output logic        regWrite2,
  output logic        illegal,
  output logic        mem_timeout,
  output logic [15:0] retired
);

  localparam logic [8:0] TO_LIM = 9'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [4:0]  slot0_q, slot0_d, slot1_q, slot1_d;
  logic        src_q, src_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [15:0] retired_q, retired_d;
  logic [8:0]  cnt_inc;
  slot_dec_t   dec0, dec1;

  // Only the opcode fields of a bundle carry meaning; the rest is dropped.
  logic unused_bits;
  assign unused_bits = ^{instr[31:21], instr[15:5], dec0.load, dec0.store,
                         dec1.alu, dec1.imm};

  slot_decode #(.SLOT(0)) u_dec0 (.op_i(slot0_q), .dec_o(dec0));
  slot_decode #(.SLOT(1)) u_dec1 (.op_i(slot1_q), .dec_o(dec1));

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;
  assign retired = retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      slot0_q   <= OP_NOP;
      slot1_q   <= OP_NOP;
      src_q     <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      src_q     <= src_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    src_d       = src_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    retired_d   = retired_q;
    instr_ready = 1'b0;
    alu_en      = 1'b0;
    aluSrcA     = src_q;  // holds the last EXEC selection between bundles
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    regWrite1   = 1'b0;
    regWrite2   = 1'b0;
    illegal     = 1'b0;
    mem_timeout = 1'b0;

    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          slot0_d = instr[4:0];
          slot1_d = instr[20:16];
          done_d  = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec0.illegal || dec1.illegal) begin
          illegal = 1'b1;
          state_d = S_IDLE;
        end else if (dec0.alu) begin
          state_d = S_EXEC;
        end else if (is_mem(dec1)) begin
          cnt_d   = '0;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_EXEC: begin
        alu_en  = 1'b1;
        aluSrcA = dec0.imm;
        src_d   = dec0.imm;
        if (is_mem(dec1)) begin
          cnt_d   = '0;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = dec1.store;
        cnt_d   = cnt_inc[7:0];
        // Ack is checked first so an ack on the final allowed cycle still completes.
        if (mem_ack) begin
          done_d  = 1'b1;
          state_d = S_WB;
        end else if (cnt_inc == TO_LIM) begin
          mem_timeout = 1'b1;
          done_d      = 1'b0;
          state_d     = S_WB;
        end
      end
      S_WB: begin
        regWrite1 = dec0.alu;
        regWrite2 = dec1.load & done_q;
        retired_d = retired_q + 16'd1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bundle_seq.sv
module tb_bundle_seq;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        mem_ack = 1'b0;
  logic        instr_ready, alu_en, aluSrcA, mem_req, mem_we;
  logic        regWrite1, regWrite2, illegal, mem_timeout;
  logic [15:0] retired;

  bundle_seq #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_en(alu_en), .aluSrcA(aluSrcA),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .regWrite1(regWrite1), .regWrite2(regWrite2), .illegal(illegal),
    .mem_timeout(mem_timeout), .retired(retired)
  );

  always #5 clk = ~clk;

  // Cycle indices are relative to the acceptance cycle N (0 = never seen).
  typedef struct {
    int ill_c, alu_c, src_alu, mem_n, we, to_c, rw1_c, rw2_c, ready_c, src_hold, ret_inc;
  } res_t;

  typedef struct {
    logic [31:0] instr;
    int          ack_at;  // MEM cycle (1-based) carrying mem_ack, 0 = never
    res_t        exp;
  } vec_t;

  int          n_cmp = 0, n_fail = 0;
  int          exp_ret = 0, last_src = 0;
  vec_t        tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t r(int ill_c, int alu_c, int src_alu, int mem_n, int we, int to_c,
                             int rw1_c, int rw2_c, int ready_c, int src_hold, int ret_inc);
    res_t x;
    x.ill_c = ill_c; x.alu_c = alu_c; x.src_alu = src_alu; x.mem_n = mem_n; x.we = we;
    x.to_c = to_c; x.rw1_c = rw1_c; x.rw2_c = rw2_c; x.ready_c = ready_c;
    x.src_hold = src_hold; x.ret_inc = ret_inc;
    return x;
  endfunction

  // Reference: walk the bundle's stage list and add up cycles.
  function automatic res_t model(input logic [31:0] in, input int ack_at, input int prev_src);
    res_t e = '{default: 0};
    int   s0 = int'(in[4:0]);
    int   s1 = int'(in[20:16]);
    bit   alu = (s0 == 8) || (s0 == 5);
    bit   ld = (s1 == 10);
    bit   st = (s1 == 11);
    bit   legal = (alu || s0 == 0) && (ld || st || s1 == 0);
    bit   acked = (ack_at >= 1) && (ack_at <= T);
    int   c = 2;
    e.src_hold = prev_src;
    if (!legal) begin
      e.ill_c = 1; e.ready_c = 2;
      return e;
    end
    if (alu) begin
      e.alu_c = 2; e.src_alu = (s0 == 5) ? 1 : 0; e.src_hold = e.src_alu; c = 3;
    end
    if (ld || st) begin
      e.mem_n = acked ? ack_at : T;
      e.we = st ? 1 : 0;
      if (!acked) e.to_c = c + T - 1;
      c += e.mem_n;
    end
    e.rw1_c = alu ? c : 0;
    e.rw2_c = (ld && acked) ? c : 0;
    e.ready_c = c + 1;
    e.ret_inc = 1;
    return e;
  endfunction

  task automatic run_bundle(input logic [31:0] in, input int ack_at, output res_t g,
                            output int pulses, output logic [15:0] ret_at);
    int          memk = 0;
    logic [15:0] ret0;
    g = '{default: 0};
    pulses = 0;
    ret_at = '0;
    for (int w = 0; w < 50 && !instr_ready; w++) @(negedge clk);
    chk("start_ready", 32'(instr_ready), 1);
    ret0 = retired;
    instr = in;
    instr_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_req) memk++;
      mem_ack = mem_req ? (memk == ack_at) : 1'($urandom_range(0, 1));
      #1;
      if (illegal)     begin pulses++; if (g.ill_c == 0) g.ill_c = k; end
      if (alu_en)      begin pulses++; if (g.alu_c == 0) begin g.alu_c = k; g.src_alu = int'(aluSrcA); end end
      if (mem_timeout) begin pulses++; if (g.to_c == 0) g.to_c = k; end
      if (regWrite1)   begin pulses++; if (g.rw1_c == 0) g.rw1_c = k; end
      if (regWrite2)   begin pulses++; if (g.rw2_c == 0) g.rw2_c = k; end
      if (mem_req) g.mem_n++;
      if (mem_we) g.we = 1;
      if (instr_ready) begin
        g.ready_c = k; g.src_hold = int'(aluSrcA); ret_at = retired;
        g.ret_inc = int'(16'(retired - ret0));
        instr_valid = 1'b0; mem_ack = 1'b0;
        break;
      end
      // Junk offered outside IDLE must be ignored.
      instr_valid = 1'($urandom_range(0, 1));
      instr = $urandom;
    end
    if (g.ready_c == 0) begin
      chk("bundle_timeout", 0, 1);
      instr_valid = 1'b0; mem_ack = 1'b0;
    end
  endtask

  task automatic check_res(input string tag, input res_t g, input res_t e,
                           input int pulses, input logic [15:0] ret_at);
    int ep = (e.ill_c != 0) + (e.alu_c != 0) + (e.to_c != 0) + (e.rw1_c != 0) + (e.rw2_c != 0);
    chk({tag, ".illegal_c"}, g.ill_c, e.ill_c);
    chk({tag, ".alu_en_c"},  g.alu_c, e.alu_c);
    chk({tag, ".aluSrcA"},   g.src_alu, e.src_alu);
    chk({tag, ".mem_cycles"}, g.mem_n, e.mem_n);
    chk({tag, ".mem_we"},    g.we, e.we);
    chk({tag, ".timeout_c"}, g.to_c, e.to_c);
    chk({tag, ".regWrite1_c"}, g.rw1_c, e.rw1_c);
    chk({tag, ".regWrite2_c"}, g.rw2_c, e.rw2_c);
    chk({tag, ".ready_c"},   g.ready_c, e.ready_c);
    chk({tag, ".aluSrcA_hold"}, g.src_hold, e.src_hold);
    chk({tag, ".retired_inc"}, g.ret_inc, e.ret_inc);
    chk({tag, ".pulse_count"}, pulses, ep);
    exp_ret = (exp_ret + e.ret_inc) & 32'hFFFF;
    chk({tag, ".retired"}, 32'(ret_at), exp_ret);
    last_src = e.src_hold;
  endtask

  initial begin
    res_t        g, e;
    int          pulses, badp;
    logic [15:0] ret_at;
    logic [31:0] ri;
    int          ra;

    //              ill alu src mem we to rw1 rw2 rdy hold ret
    tbl[0]  = '{32'h0000_0008, 0, r(0, 2, 0, 0, 0, 0, 3, 0, 4, 0, 1)};
    tbl[1]  = '{32'h000A_0005, 3, r(0, 2, 1, 3, 0, 0, 6, 6, 7, 1, 1)};
    tbl[2]  = '{32'h000B_0000, 0, r(0, 0, 0, 8, 1, 9, 0, 0, 11, 1, 1)};
    tbl[3]  = '{32'h0000_001F, 0, r(1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0)};
    tbl[4]  = '{32'h0001_0008, 0, r(1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0)};
    tbl[5]  = '{32'h0000_0000, 0, r(0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1)};
    tbl[6]  = '{32'h000B_0008, 1, r(0, 2, 0, 1, 1, 0, 4, 0, 5, 0, 1)};
    tbl[7]  = '{32'h000A_0000, 0, r(0, 0, 0, 8, 0, 9, 0, 0, 11, 0, 1)};
    tbl[8]  = '{32'h000A_0005, 8, r(0, 2, 1, 8, 0, 0, 11, 11, 12, 1, 1)};
    tbl[9]  = '{32'h0000_0005, 0, r(0, 2, 1, 0, 0, 0, 3, 0, 4, 1, 1)};
    tbl[10] = '{32'hFFE0_FFE8, 0, r(0, 2, 0, 0, 0, 0, 3, 0, 4, 0, 1)};
    tbl[11] = '{32'h000B_0000, 5, r(0, 0, 0, 5, 1, 0, 0, 0, 8, 0, 1)};

    // Reset state
    #3;
    chk("rst.instr_ready", 32'(instr_ready), 1);
    chk("rst.outputs", 32'({alu_en, aluSrcA, mem_req, mem_we, regWrite1, regWrite2,
                            illegal, mem_timeout}), 0);
    chk("rst.retired", 32'(retired), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Directed table
    foreach (tbl[i]) begin
      run_bundle(tbl[i].instr, tbl[i].ack_at, g, pulses, ret_at);
      check_res($sformatf("vec%0d", i), g, tbl[i].exp, pulses, ret_at);
    end

    // Randomized bundles against the reference model
    for (int n = 0; n < 80; n++) begin
      ri = $urandom;
      case ($urandom_range(0, 3))
        0: ri[4:0] = 5'b01000;
        1: ri[4:0] = 5'b00101;
        2: ri[4:0] = 5'b00000;
        default: ri[4:0] = 5'($urandom_range(0, 31));
      endcase
      case ($urandom_range(0, 3))
        0: ri[20:16] = 5'b01010;
        1: ri[20:16] = 5'b01011;
        2: ri[20:16] = 5'b00000;
        default: ri[20:16] = 5'($urandom_range(0, 31));
      endcase
      ra = int'($urandom_range(0, 10));
      e = model(ri, ra, last_src);
      run_bundle(ri, ra, g, pulses, ret_at);
      check_res($sformatf("rnd%0d", n), g, e, pulses, ret_at);
    end

    // Reset asserted during MEM of a store
    instr = 32'h000B_0000;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    #1 chk("rstmem.mem_req_before", 32'(mem_req), 1);
    #2 reset = 1'b1;
    #1;
    chk("rstmem.mem_req_async", 32'(mem_req), 0);
    chk("rstmem.ready_async", 32'(instr_ready), 1);
    badp = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 2) reset = 1'b0;
      #1 badp += int'(regWrite1) + int'(regWrite2) + int'(alu_en) + int'(mem_req);
    end
    chk("rstmem.no_pulses", badp, 0);
    chk("rstmem.retired", 32'(retired), 0);
    chk("rstmem.aluSrcA", 32'(aluSrcA), 0);
    exp_ret = 0;
    last_src = 0;

    // Wrap: 65535 NOP/NOP bundles back to back (3 cycles each), then one more
    instr = 32'h0;
    instr_valid = 1'b1;
    repeat (3 * 65535) @(negedge clk);
    instr_valid = 1'b0;
    #1;
    chk("wrap.preload", 32'(retired), 32'hFFFF);
    chk("wrap.ready", 32'(instr_ready), 1);
    exp_ret = 32'hFFFF;
    e = model(32'h0, 0, last_src);
    run_bundle(32'h0, 0, g, pulses, ret_at);
    check_res("wrap", g, e, pulses, ret_at);
    chk("wrap.zero", 32'(retired), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
